// File: rtl/reg_wb_queue.sv
// reg_wb_queue: write-back FIFO feeding the reg_file write port when the main pipeline leaves it idle.
//   Parameters: DEPTH (entries, power of 2, >=2), DATA_W (data width), ADDR_W (register index width).
//   Ports:
//     clk, rst (async, active-low)
//     req_valid/req_ready/req_rd/req_data : producer write request (rd==0 accepted and dropped)
//     pipe_we                             : main pipeline owns the write port, drain stalls
//     RegWrite/Rd/Write_data              : reg_file write port (0 when idle)
//     Rs1/Rs2 -> rs1_pending/rs2_pending  : a queued write targets that source register
//     count                               : occupied entries
//   Optional: define WBQ_BYPASS_EN to route a request straight to the write port when the queue is empty.
module reg_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_rd,
    input  logic [DATA_W-1:0]        req_data,
    input  logic                     pipe_we,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        Rd,
    output logic [DATA_W-1:0]        Write_data,
    input  logic [ADDR_W-1:0]        Rs1,
    input  logic [ADDR_W-1:0]        Rs2,
    output logic                     rs1_pending,
    output logic                     rs2_pending,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              push, pop, bypass;

    assign req_ready = (count_q != DEPTH[PW:0]);
    assign pop       = (count_q != '0) && !pipe_we;
`ifdef WBQ_BYPASS_EN
    // Empty queue and free port: the request skips storage entirely.
    assign bypass    = (count_q == '0) && !pipe_we && req_valid && (req_rd != '0);
`else
    assign bypass    = 1'b0;
`endif
    assign push      = req_valid && req_ready && (req_rd != '0) && !bypass;
    assign count     = count_q;

    assign RegWrite   = pop || bypass;
    assign Rd         = bypass ? req_rd   : pop ? rd_q[rd_ptr_q]   : '0;
    assign Write_data = bypass ? req_data : pop ? data_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        valid_d  = valid_q;
        // Push and pop never hit the same slot: that needs a full or empty queue.
        if (pop)  valid_d[rd_ptr_q] = 1'b0;
        if (push) valid_d[wr_ptr_q] = 1'b1;
    end

    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rd_q[i] == Rs1) rs1_pending = 1'b1;
            if (valid_q[i] && rd_q[i] == Rs2) rs2_pending = 1'b1;
        end
        rs1_pending = rs1_pending && (Rs1 != '0);
        rs2_pending = rs2_pending && (Rs2 != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr_q]   <= req_rd;
            data_q[wr_ptr_q] <= req_data;
        end
    end
endmodule
